cond_flag_unit: RTL

- Execute-stage condition unit. Holds the architectural NZCV register and evaluates the instruction's condition field against it.
- Gates RegWrite, MemWrite and PCSrc with the condition result, and updates NZCV from the ALU under the 2-bit FlagW produced by the ALU decoder.
- Resolves conditional branches against the fetch-stage prediction and raises a redirect on mispredict.
- Keeps saturating branch and mispredict counters for the branch-predictor study.

---
 rtl/cond_flag_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: execute-stage NZCV register, condition evaluation, write gating,
// branch resolution with redirect, and saturating branch/mispredict statistics.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallE,
   input  logic             ValidE,
   input  logic [3:0]       CondE,
   input  logic [1:0]       FlagWriteE,
   input  logic [3:0]       ALUFlags,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic             PCSrcE,
   input  logic             BranchE,
   input  logic             PredTakenE,
   output logic [3:0]       Flags,
   output logic             CondExE,
   output logic             RegWriteGE,
   output logic             MemWriteGE,
   output logic             BranchTakenE,
   output logic             MispredictE,
   output logic             RedirectE,
   output logic             RedirectSelE,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] MispredCount
);
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;
   logic             n, z, c, v, resolve, upd;
   assign {n, z, c, v} = flags_q;
   always_comb begin
      CondExE = 1'b1;
      case (CondE)
         4'b0000: CondExE = z;
         4'b0001: CondExE = !z;
         4'b0010: CondExE = c;
         4'b0011: CondExE = !c;
         4'b0100: CondExE = n;
         4'b0101: CondExE = !n;
         4'b0110: CondExE = v;
         4'b0111: CondExE = !v;
         4'b1000: CondExE = c & !z;
         4'b1001: CondExE = !c | z;
         4'b1010: CondExE = n == v;
         4'b1011: CondExE = n != v;
         4'b1100: CondExE = !z & (n == v);
         4'b1101: CondExE = z | (n != v);
         default: CondExE = 1'b1;
      endcase
   end
   assign RegWriteGE   = RegWriteE & CondExE & ValidE;
   assign MemWriteGE   = MemWriteE & CondExE & ValidE;
   assign BranchTakenE = BranchE & CondExE & ValidE;
   assign resolve      = ValidE & BranchE & !StallE;
   assign MispredictE  = resolve & (CondExE != PredTakenE);
   assign RedirectSelE = MispredictE & !CondExE;
   // A branch owns the redirect decision; PCSrcE only matters for non-branches.
   assign RedirectE    = MispredictE | (ValidE & !StallE & !BranchE & PCSrcE & CondExE);
   assign upd          = ValidE & CondExE & !StallE;
   always_comb begin
      flags_d = {(upd & FlagWriteE[1]) ? ALUFlags[3:2] : flags_q[3:2],
                 (upd & FlagWriteE[0]) ? ALUFlags[1:0] : flags_q[1:0]};
      bcnt_d  = (resolve && bcnt_q != '1) ? bcnt_q + 1'b1 : bcnt_q;
      mcnt_d  = (MispredictE && mcnt_q != '1) ? mcnt_q + 1'b1 : mcnt_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_q <= '0;
         bcnt_q  <= '0;
         mcnt_q  <= '0;
      end else begin
         flags_q <= flags_d;
         bcnt_q  <= bcnt_d;
         mcnt_q  <= mcnt_d;
      end
   end
   assign Flags        = flags_q;
   assign BranchCount  = bcnt_q;
   assign MispredCount = mcnt_q;
endmodule
